// File: rtl/receive_all_pkg.sv
// Shared definitions for the inter-board Request/Ack receiver: word/field widths,
// message-type codes agreed with send_all and GameControl, and FSM state types.
package receive_all_pkg;

   localparam int WORD_W     = 6;
   localparam int MSG_TYPE_W = 3;
   localparam int NUMBER_W   = 5;

   localparam logic [MSG_TYPE_W-1:0] MSG_NONE   = 3'd0;
   localparam logic [MSG_TYPE_W-1:0] MSG_START  = 3'd1;
   localparam logic [MSG_TYPE_W-1:0] MSG_MOVE   = 3'd2;
   localparam logic [MSG_TYPE_W-1:0] MSG_SCORE  = 3'd3;
   localparam logic [MSG_TYPE_W-1:0] MSG_RESULT = 3'd4;
   localparam logic [MSG_TYPE_W-1:0] MSG_END    = 3'd7;

   typedef enum logic {
      WAIT_REQ,
      ACK_HIGH
   } single_state_t;

   typedef enum logic {
      WAIT_TYPE,
      WAIT_NUM
   } all_state_t;

endpackage

// File: rtl/receive_single.sv
// One-word receiver: synchronizes Request/data from the other board's clock domain
// and runs the 4-phase Request/Ack handshake, emitting one word_valid per Request pulse.
module receive_single
   import receive_all_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request,
   input  logic [WORD_W-1:0] data,
   output logic              ack,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [SYNC_STAGES-1:0] req_sync;
   logic [SYNC_STAGES-1:0] fill;
   logic [WORD_W-1:0]      data_sync [SYNC_STAGES];
   logic                   req_s;
   logic [WORD_W-1:0]      data_s;
   logic                   armed;
   logic                   capture;
   single_state_t          state;
   single_state_t          state_nxt;

   assign req_s  = req_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // fill marks when req_s carries a real post-reset sample rather than the cleared chain,
   // so a Request held high across reset cannot arm the receiver through a fake 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_sync <= '0;
         fill     <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            data_sync[i] <= '0;
         end
      end else begin
         req_sync     <= {req_sync[SYNC_STAGES-2:0], request};
         fill         <= {fill[SYNC_STAGES-2:0], 1'b1};
         data_sync[0] <= data;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
      end else if (fill[SYNC_STAGES-1] && !req_s) begin
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         WAIT_REQ: begin
            if (armed && req_s) begin
               state_nxt = ACK_HIGH;
               capture   = 1'b1;
            end
         end
         ACK_HIGH: begin
            if (!req_s) begin
               state_nxt = WAIT_REQ;
            end
         end
         default: state_nxt = WAIT_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_REQ;
         ack        <= 1'b0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         ack        <= (state_nxt == ACK_HIGH);
         word_valid <= capture;
         if (capture) begin
            word <= data_s;
         end
      end
   end

endmodule

// File: rtl/receive_all.sv
// Inter-board message receiver: assembles two handshaked words (type, number) into one
// recv_en pulse, dropping a half-received message after TIMEOUT_CYCLES.
module receive_all
   import receive_all_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  interboard_rst,
   input  logic                  Request_in,
   input  logic [WORD_W-1:0]     inter_data_in,
   output logic                  Ack_out,
   output logic                  recv_en,
   output logic [MSG_TYPE_W-1:0] recv_msg_type,
   output logic [NUMBER_W-1:0]   recv_number,
   output logic                  recv_busy,
   output logic                  recv_timeout
);

   localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic                  rst_all;
   logic [WORD_W-1:0]     word;
   logic                  word_valid;
   logic                  unused_word_msb;

   all_state_t            state;
   all_state_t            state_nxt;
   logic [TIMER_W-1:0]    timer;
   logic [TIMER_W-1:0]    timer_nxt;
   logic [MSG_TYPE_W-1:0] type_r;
   logic [MSG_TYPE_W-1:0] type_nxt;
   logic [MSG_TYPE_W-1:0] msg_type_nxt;
   logic [NUMBER_W-1:0]   number_nxt;
   logic                  en_nxt;
   logic                  timeout_nxt;

   assign rst_all         = rst | interboard_rst;
   assign unused_word_msb = word[WORD_W-1];

   receive_single #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_single (
      .clk        (clk),
      .rst        (rst_all),
      .request    (Request_in),
      .data       (inter_data_in),
      .ack        (Ack_out),
      .word       (word),
      .word_valid (word_valid)
   );

   // A word arriving on the last timer cycle still completes the message.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      type_nxt     = type_r;
      msg_type_nxt = recv_msg_type;
      number_nxt   = recv_number;
      en_nxt       = 1'b0;
      timeout_nxt  = 1'b0;
      case (state)
         WAIT_TYPE: begin
            if (word_valid) begin
               type_nxt  = word[MSG_TYPE_W-1:0];
               timer_nxt = '0;
               state_nxt = WAIT_NUM;
            end
         end
         WAIT_NUM: begin
            if (word_valid) begin
               msg_type_nxt = type_r;
               number_nxt   = word[NUMBER_W-1:0];
               en_nxt       = 1'b1;
               state_nxt    = WAIT_TYPE;
            end else if (timer == TIMER_LAST) begin
               timeout_nxt = 1'b1;
               state_nxt   = WAIT_TYPE;
            end else begin
               timer_nxt = timer + TIMER_W'(1);
            end
         end
         default: state_nxt = WAIT_TYPE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_all) begin
         state         <= WAIT_TYPE;
         timer         <= '0;
         type_r        <= '0;
         recv_msg_type <= '0;
         recv_number   <= '0;
         recv_en       <= 1'b0;
         recv_timeout  <= 1'b0;
         recv_busy     <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         type_r        <= type_nxt;
         recv_msg_type <= msg_type_nxt;
         recv_number   <= number_nxt;
         recv_en       <= en_nxt;
         recv_timeout  <= timeout_nxt;
         recv_busy     <= (state_nxt == WAIT_NUM);
      end
   end

endmodule

// File: tb/tb_receive_all.sv
// Scoreboard bench for receive_all: a behavioural 4-phase sender drives the link,
// expected messages/timeouts are queued and checked by an independent monitor.
module tb_receive_all;

   logic       clk = 1'b0;
   logic       rst;
   logic       interboard_rst;
   logic       Request_in;
   logic [5:0] inter_data_in;
   logic       Ack_out;
   logic       recv_en;
   logic [2:0] recv_msg_type;
   logic [4:0] recv_number;
   logic       recv_busy;
   logic       recv_timeout;

   typedef struct {
      bit       is_to;
      bit [2:0] t;
      bit [4:0] n;
   } exp_t;

   exp_t q[$];
   int   tests    = 0;
   int   fails    = 0;
   int   wv_count = 0;
   bit   mon_en   = 0;
   bit   rst_hit  = 0;
   bit [2:0] last_t = 0;
   bit [4:0] last_n = 0;

   always #5 clk = ~clk;

   receive_all #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (interboard_rst),
      .Request_in     (Request_in),
      .inter_data_in  (inter_data_in),
      .Ack_out        (Ack_out),
      .recv_en        (recv_en),
      .recv_msg_type  (recv_msg_type),
      .recv_number    (recv_number),
      .recv_busy      (recv_busy),
      .recv_timeout   (recv_timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_msg(input bit [2:0] t, input bit [4:0] n);
      exp_t e;
      e.is_to = 1'b0;
      e.t     = t;
      e.n     = n;
      q.push_back(e);
   endtask

   task automatic push_timeout();
      exp_t e;
      e.is_to = 1'b1;
      e.t     = '0;
      e.n     = '0;
      q.push_back(e);
   endtask

   task automatic send_word(input logic [5:0] w);
      int n;
      n = 0;
      while (Ack_out && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_ack_idle", Ack_out, 1'b0);
      inter_data_in = w;
      Request_in    = 1'b1;
      n = 0;
      while (!Ack_out && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_ack_rise", Ack_out, 1'b1);
      Request_in = 1'b0;
      n = 0;
      while (Ack_out && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_ack_fall", Ack_out, 1'b0);
   endtask

   always @(posedge clk) rst_hit <= rst | interboard_rst;

   // Monitor: pops the scoreboard on every output pulse, otherwise checks hold.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (rst_hit) begin
               last_t = '0;
               last_n = '0;
            end
            if (dut.u_single.word_valid) wv_count++;
            if (recv_en || recv_timeout) begin
               if (q.size() == 0) begin
                  check("unexpected_pulse", {recv_en, recv_timeout}, 2'b00);
               end else begin
                  e = q.pop_front();
                  check("pulse_kind", {recv_en, recv_timeout}, e.is_to ? 2'b01 : 2'b10);
                  if (!e.is_to) begin
                     check("msg_type", recv_msg_type, e.t);
                     check("number", recv_number, e.n);
                     last_t = e.t;
                     last_n = e.n;
                  end
               end
            end else begin
               check("hold_type", recv_msg_type, last_t);
               check("hold_number", recv_number, last_n);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int wv0;
      rst            = 1'b1;
      interboard_rst = 1'b0;
      Request_in     = 1'b0;
      inter_data_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_ack", Ack_out, 1'b0);
      check("rst_en", recv_en, 1'b0);
      check("rst_type", recv_msg_type, 3'd0);
      check("rst_number", recv_number, 5'd0);
      check("rst_busy", recv_busy, 1'b0);
      check("rst_timeout", recv_timeout, 1'b0);
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);

      // basic message type 2, number 17
      push_msg(3'd2, 5'd17);
      send_word(6'd2);
      send_word(6'd17);
      repeat (4) @(negedge clk);
      check("loop_ack_idle", Ack_out, 1'b0);
      check("loop_busy_idle", recv_busy, 1'b0);

      // manual handshake, 20-cycle hold: one word only, and the lone word times out
      push_timeout();
      wv0           = wv_count;
      inter_data_in = 6'h05;
      Request_in    = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!Ack_out && n < 10);
      check("ack_rise_latency", n, 3);
      repeat (20) @(negedge clk);
      check("single_word_valid", wv_count - wv0, 1);
      Request_in = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (Ack_out && n < 10);
      check("ack_fall_latency", n, 3);
      repeat (4) @(negedge clk);

      // exact timeout distance, then a good message
      push_timeout();
      fork
         send_word(6'h03);
         begin
            n = 0;
            while (!recv_busy && n < 50) begin
               @(negedge clk);
               n++;
            end
            if (n >= 50) check("busy_rise", recv_busy, 1'b1);
            n = 0;
            while (!recv_timeout && n < 50) begin
               @(negedge clk);
               n++;
            end
            check("timeout_delay", n, 16);
         end
      join
      @(negedge clk);
      check("busy_after_timeout", recv_busy, 1'b0);
      push_msg(3'd1, 5'd9);
      send_word(6'h01);
      send_word(6'h09);
      repeat (4) @(negedge clk);

      // reset while ACK_HIGH with Request still high
      wv0           = wv_count;
      inter_data_in = 6'h04;
      Request_in    = 1'b1;
      n = 0;
      while (!Ack_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_ack", Ack_out, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("ack_after_rst", Ack_out, 1'b0);
      check("busy_after_rst", recv_busy, 1'b0);
      repeat (12) @(negedge clk);
      check("no_stale_capture", wv_count - wv0, 1);
      check("ack_stale_low", Ack_out, 1'b0);
      Request_in = 1'b0;
      repeat (5) @(negedge clk);
      push_msg(3'd6, 5'd21);
      send_word(6'h06);
      send_word(6'h15);
      repeat (4) @(negedge clk);

      // interboard_rst drops a half message silently
      send_word(6'h02);
      check("ib_busy", recv_busy, 1'b1);
      interboard_rst = 1'b1;
      @(negedge clk);
      interboard_rst = 1'b0;
      check("ib_busy_clear", recv_busy, 1'b0);
      repeat (25) @(negedge clk);

      // word 2 lands on the last timer cycle; upper word bits ignored
      push_msg(3'd3, 5'd10);
      inter_data_in = 6'h3B;
      Request_in    = 1'b1;
      repeat (3) @(negedge clk);
      check("coinc_ack_high", Ack_out, 1'b1);
      Request_in = 1'b0;
      repeat (13) @(negedge clk);
      inter_data_in = 6'h2A;
      Request_in    = 1'b1;
      n = 0;
      while (!Ack_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      Request_in = 1'b0;
      n = 0;
      while (Ack_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);

      // back-to-back messages, words (31,0) then (7,31)
      push_msg(3'd7, 5'd0);
      push_msg(3'd7, 5'd31);
      send_word(6'd31);
      send_word(6'd0);
      send_word(6'd7);
      send_word(6'd31);
      repeat (30) @(negedge clk);

      check("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
